dbus_stream_responder: RTL

- Memory-mapped responder on the core's data bus (ReadEnable/WriteEnable/ByteEnable/Address/WriteData/ReadData).
- Bridges CPU loads/stores to two word FIFOs:
  - TX: CPU stores, drained by an external valid/ready stream.
  - RX: filled by an external stream, drained by CPU loads.
- Read data is combinational, so the single-cycle core completes a load in the same cycle. All state changes occur on the clock edge.

---
 rtl/dbus_stream_responder_pkg.sv | 34 +++
 rtl/dbus_stream_responder_if.sv | 29 ++
 rtl/dbus_stream_responder_sync_fifo.sv | 58 +++++
 rtl/dbus_stream_responder.sv | 115 +++++++++++
 4 files changed

// File: rtl/dbus_stream_responder_pkg.sv
// Shared register map, bit positions and byte-lane helper for the data-bus
// stream responder.
package dbus_stream_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_RXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int ST_TX_EMPTY     = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_RX_EMPTY     = 2;
  localparam int ST_RX_FULL      = 3;
  localparam int ST_TXOVF        = 4;
  localparam int ST_RXUND        = 5;
  localparam int ST_TX_COUNT_LSB = 8;
  localparam int ST_RX_COUNT_LSB = 16;

  localparam int CTRL_IRQ_RX_EN      = 0;
  localparam int CTRL_IRQ_TXEMPTY_EN = 1;
  localparam int CTRL_TX_FLUSH       = 2;
  localparam int CTRL_RX_FLUSH       = 3;

  // Disabled byte lanes of a store are zeroed rather than preserved.
  function automatic logic [31:0] maskBytes(input logic [31:0] data, input logic [3:0] byteEnable);
    logic [31:0] res;
    res = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = byteEnable[i] ? data[8*i +: 8] : 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/dbus_stream_responder_if.sv
// Data-bus and stream signals of the responder; slave = responder, master = CPU/stream side.
interface dbus_stream_if;
  logic        iReadEnable;
  logic        iWriteEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic [31:0] oReadData;
  logic        oHit;
  logic        oIRQ;
  logic        oTxValid;
  logic [31:0] oTxData;
  logic        iTxReady;
  logic        iRxValid;
  logic [31:0] iRxData;
  logic        oRxReady;

  modport slave (
    input  iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData,
    input  iTxReady, iRxValid, iRxData,
    output oReadData, oHit, oIRQ, oTxValid, oTxData, oRxReady
  );

  modport master (
    output iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData,
    output iTxReady, iRxValid, iRxData,
    input  oReadData, oHit, oIRQ, oTxValid, oTxData, oRxReady
  );
endinterface

// File: rtl/dbus_stream_responder_sync_fifo.sv
// Single-clock word FIFO; push on full and pop on empty are silently ignored,
// flush empties it and overrides any push/pop in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [CW-1:0]    cnt;
  logic             doPush;
  logic             doPop;

  assign empty  = (cnt == CW'(0));
  assign full   = (cnt == CW'(DEPTH));
  assign doPush = push & ~full & ~flush;
  assign doPop  = pop & ~empty & ~flush;
  assign count  = cnt;
  assign dout   = empty ? {WIDTH{1'b0}} : mem[rdPtr];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge iCLK) begin
    if (doPush) begin
      mem[wrPtr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      cnt <= cnt + CW'(doPush) - CW'(doPop);
    end
  end
endmodule

// File: rtl/dbus_stream_responder.sv
// Memory-mapped responder bridging CPU loads/stores to a TX and an RX word FIFO.
// Read data and hit are combinational so a single-cycle core completes loads in one cycle.
module dbus_stream_responder
  import dbus_stream_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFF20_0000,
  parameter int          DEPTH     = 8
) (
  input logic           iCLK,
  input logic           iRST,
  dbus_stream_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          hit, rdSel, wrSel, ctrlWr, statusWr;
  logic [1:0]    off;
  logic          txPush, txPop, txFlush, txEmpty, txFull;
  logic          rxPush, rxPop, rxFlush, rxEmpty, rxFull, rxReady;
  logic [31:0]   txWord, txHead, rxHead, statusWord, readData;
  logic [CW-1:0] txCount, rxCount;
  logic          txOvf, rxUnd, irqRxEn, irqTxEmptyEn, irq;
  logic          unusedAddrBits;

  assign hit      = (bus.iAddress[31:4] == BASE_ADDR[31:4]);
  assign off      = bus.iAddress[3:2];
  assign rdSel    = hit & bus.iReadEnable;
  assign wrSel    = hit & bus.iWriteEnable;
  assign ctrlWr   = wrSel & (off == OFF_CTRL) & bus.iByteEnable[0];
  assign statusWr = wrSel & (off == OFF_STATUS) & bus.iByteEnable[0];
  assign unusedAddrBits = ^bus.iAddress[1:0];

  assign txWord  = maskBytes(bus.iWriteData, bus.iByteEnable);
  assign txPush  = wrSel & (off == OFF_TXDATA);
  assign txFlush = ctrlWr & bus.iWriteData[CTRL_TX_FLUSH];
  assign txPop   = ~txEmpty & bus.iTxReady;

  assign rxReady = ~rxFull & iRST;
  assign rxPush  = bus.iRxValid & rxReady;
  assign rxPop   = rdSel & (off == OFF_RXDATA);
  assign rxFlush = ctrlWr & bus.iWriteData[CTRL_RX_FLUSH];

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) uTxFifo (
    .iCLK(iCLK), .iRST(iRST), .push(txPush), .pop(txPop), .flush(txFlush),
    .din(txWord), .dout(txHead), .empty(txEmpty), .full(txFull), .count(txCount)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) uRxFifo (
    .iCLK(iCLK), .iRST(iRST), .push(rxPush), .pop(rxPop), .flush(rxFlush),
    .din(bus.iRxData), .dout(rxHead), .empty(rxEmpty), .full(rxFull), .count(rxCount)
  );

  // Sticky error flags (set beats W1C clear), control bits and registered IRQ.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      txOvf        <= 1'b0;
      rxUnd        <= 1'b0;
      irqRxEn      <= 1'b0;
      irqTxEmptyEn <= 1'b0;
      irq          <= 1'b0;
    end else begin
      if (txPush & txFull & ~txFlush)                txOvf <= 1'b1;
      else if (statusWr & bus.iWriteData[ST_TXOVF])  txOvf <= 1'b0;
      else                                           txOvf <= txOvf;

      if (rxPop & rxEmpty)                           rxUnd <= 1'b1;
      else if (statusWr & bus.iWriteData[ST_RXUND])  rxUnd <= 1'b0;
      else                                           rxUnd <= rxUnd;

      if (ctrlWr) begin
        irqRxEn      <= bus.iWriteData[CTRL_IRQ_RX_EN];
        irqTxEmptyEn <= bus.iWriteData[CTRL_IRQ_TXEMPTY_EN];
      end else begin
        irqRxEn      <= irqRxEn;
        irqTxEmptyEn <= irqTxEmptyEn;
      end

      irq <= (irqRxEn & ~rxEmpty) | (irqTxEmptyEn & txEmpty);
    end
  end

  // STATUS word assembly.
  always_comb begin
    statusWord = 32'h0000_0000;
    statusWord[ST_TX_EMPTY] = txEmpty;
    statusWord[ST_TX_FULL]  = txFull;
    statusWord[ST_RX_EMPTY] = rxEmpty;
    statusWord[ST_RX_FULL]  = rxFull;
    statusWord[ST_TXOVF]    = txOvf;
    statusWord[ST_RXUND]    = rxUnd;
    statusWord[ST_TX_COUNT_LSB +: 8] = 8'(txCount);
    statusWord[ST_RX_COUNT_LSB +: 8] = 8'(rxCount);
  end

  // Load data mux; TXDATA and unselected reads return zero.
  always_comb begin
    readData = 32'h0000_0000;
    if (rdSel) begin
      case (off)
        OFF_RXDATA: readData = rxHead;
        OFF_STATUS: readData = statusWord;
        OFF_CTRL:   readData = {30'h0000_0000, irqTxEmptyEn, irqRxEn};
        default:    readData = 32'h0000_0000;
      endcase
    end else begin
      readData = 32'h0000_0000;
    end
  end

  assign bus.oReadData = readData;
  assign bus.oHit      = hit;
  assign bus.oIRQ      = irq;
  assign bus.oTxValid  = ~txEmpty;
  assign bus.oTxData   = txHead;
  assign bus.oRxReady  = rxReady;
endmodule
